// File: rtl/port_timer_pkg.sv
// Shared types and constants for the port-mapped timer: FSM states,
// register addresses, and bit positions of CTRL, CMD and STATUS.
package port_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_PERIOD = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_PRESC  = 2'd2;
  localparam logic [1:0] ADDR_CMD    = 2'd3;

  localparam int CTRL_START      = 0;
  localparam int CTRL_AUTORELOAD = 1;
  localparam int CTRL_IRQ_EN     = 2;

  localparam int CMD_CLEAR = 0;
  localparam int CMD_STOP  = 1;

  localparam int STAT_RUNNING  = 0;
  localparam int STAT_PENDING  = 1;
  localparam int STAT_OVERFLOW = 2;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale divider: emits one tick every (limit+1) enabled cycles.
// limit is compared live, so changing it alters spacing immediately.
module timer_prescaler #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  input  logic [PW-1:0] limit,
  output logic          tick
);

  logic [PW-1:0] presc_cnt;

  assign tick = en && (presc_cnt == limit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_cnt <= '0;
    end else if (clr) begin
      presc_cnt <= '0;
    end else if (en) begin
      presc_cnt <= tick ? '0 : presc_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/port_timer_irq.sv
// Port-mapped programmable down-counting timer with interrupt request,
// written via the CPU port-write path and acknowledged by irq_ack.
//
//   state   | meaning
//   --------+------------------------------------------
//   IDLE    | stopped, count holds
//   RUN     | counting on prescaler ticks
//   DONE    | expired without autoreload, count = 0
module port_timer_irq
  import port_timer_pkg::*;
#(
  parameter int W  = 8,
  parameter int PW = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [1:0]   wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         irq_ack,
  output logic [W-1:0] count,
  output logic [7:0]   status,
  output logic         irq
);

  state_t        state, state_nxt;
  logic [W-1:0]  period, count_nxt;
  logic [PW-1:0] presc;
  logic          irq_en, autoreload, pending, overflow;
  logic          wr_ctrl, wr_cmd, start, stop, clear, tick, expire, running;

  assign wr_ctrl = wr_en && (wr_addr == ADDR_CTRL);
  assign wr_cmd  = wr_en && (wr_addr == ADDR_CMD);
  assign start   = wr_ctrl && wr_data[CTRL_START];
  assign stop    = wr_cmd && wr_data[CMD_STOP];
  assign clear   = irq_ack || (wr_cmd && wr_data[CMD_CLEAR]);
  assign running = (state == ST_RUN);

  // A stop edge must freeze the prescaler as well as the count.
  timer_prescaler #(.PW(PW)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (running && !stop),
    .clr   (start),
    .limit (presc),
    .tick  (tick)
  );

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    expire    = 1'b0;
    if (start) begin
      state_nxt = ST_RUN;
      count_nxt = period;
    end else if (running) begin
      if (stop) begin
        state_nxt = ST_IDLE;
      end else if (tick) begin
        if (count == '0) begin
          expire = 1'b1;
          if (autoreload) count_nxt = period;
          else            state_nxt = ST_DONE;
        end else begin
          count_nxt = count - W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period     <= '0;
      presc      <= '0;
      irq_en     <= 1'b0;
      autoreload <= 1'b0;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_PERIOD: period <= wr_data;
        ADDR_PRESC:  presc  <= PW'(wr_data);
        ADDR_CTRL: begin
          irq_en     <= wr_data[CTRL_IRQ_EN];
          autoreload <= wr_data[CTRL_AUTORELOAD];
        end
        default: ;
      endcase
    end
  end

  // Expiry beats a same-cycle clear; overflow only records a missed service.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else if (expire) begin
      pending  <= 1'b1;
      overflow <= clear ? 1'b0 : (overflow || pending);
    end else if (clear) begin
      pending  <= 1'b0;
      overflow <= 1'b0;
    end
  end

  always_comb begin
    status                = '0;
    status[STAT_RUNNING]  = running;
    status[STAT_PENDING]  = pending;
    status[STAT_OVERFLOW] = overflow;
  end

  assign irq = pending && irq_en;

endmodule

// File: tb/tb_port_timer_irq.sv
// Bench for port_timer_irq: directed scenarios plus random port traffic,
// all checked each cycle against a behavioural timer model.
module tb_port_timer_irq;

  localparam int W  = 8;
  localparam int PW = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         wr_en = 1'b0;
  logic [1:0]   wr_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic         irq_ack = 1'b0;
  logic [W-1:0] count;
  logic [7:0]   status;
  logic         irq;

  port_timer_irq #(.W(W), .PW(PW)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .irq_ack (irq_ack),
    .count   (count),
    .status  (status),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: the timer as an abstract "counting" flag plus elapsed prescale cycles.
  bit m_counting;
  int m_cnt, m_elapsed, m_period, m_presc;
  bit m_ien, m_ar, m_pend, m_ovf;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_counting = 0; m_cnt = 0; m_elapsed = 0; m_period = 0; m_presc = 0;
    m_ien = 0; m_ar = 0; m_pend = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit we, input int addr, input int data, input bit ack);
    bit start, stop, clr, expired;
    start   = we && addr == 1 && data[0];
    stop    = we && addr == 3 && data[1];
    clr     = ack || (we && addr == 3 && data[0]);
    expired = 0;
    if (start) begin
      m_counting = 1; m_cnt = m_period; m_elapsed = 0;
    end else if (m_counting && stop) begin
      m_counting = 0;
    end else if (m_counting) begin
      if (m_elapsed == m_presc) begin
        m_elapsed = 0;
        if (m_cnt > 0) m_cnt = m_cnt - 1;
        else begin
          expired = 1;
          if (m_ar) m_cnt = m_period;
          else m_counting = 0;
        end
      end else begin
        m_elapsed = (m_elapsed + 1) % (1 << PW);
      end
    end
    if (expired) begin
      m_ovf  = clr ? 0 : (m_ovf | m_pend);
      m_pend = 1;
    end else if (clr) begin
      m_pend = 0; m_ovf = 0;
    end
    if (we) begin
      case (addr)
        0: m_period = data % (1 << W);
        2: m_presc  = data % (1 << PW);
        1: begin m_ien = data[2]; m_ar = data[1]; end
        default: ;
      endcase
    end
  endtask

  task automatic compare_model(input string tag);
    check_val({tag, "_count"}, 32'(count), 32'(m_cnt));
    check_val({tag, "_status"}, 32'(status), 32'(m_ovf * 4 + m_pend * 2 + m_counting));
    check_val({tag, "_irq"}, 32'(irq), 32'(m_pend & m_ien));
  endtask

  task automatic cycle(input bit we, input int addr, input int data, input bit ack, input string tag);
    @(negedge clk);
    wr_en = we; wr_addr = 2'(addr); wr_data = W'(data); irq_ack = ack;
    @(posedge clk);
    if (reset) model_step(we, addr, data, ack);
    #1 compare_model(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    wr_en = 0; irq_ack = 0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_val({tag, "_rst_count"}, 32'(count), 0);
    check_val({tag, "_rst_status"}, 32'(status), 0);
    check_val({tag, "_rst_irq"}, 32'(irq), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    check_val("reset_count", 32'(count), 0);
    check_val("reset_status", 32'(status), 0);
    check_val("reset_irq", 32'(irq), 0);
    @(negedge clk);
    reset = 1'b1;
    idle(10, "quiet");
    check_val("quiet_count", 32'(count), 0);
    check_val("quiet_status", 32'(status), 0);

    // one-shot, PERIOD 3, PRESC 0
    cycle(1, 0, 3, 0, "os_cfg");
    cycle(1, 2, 0, 0, "os_cfg");
    cycle(1, 1, 8'h05, 0, "os_start");
    check_val("os_e0_count", 32'(count), 3);
    for (int k = 1; k <= 3; k++) begin
      idle(1, "os_run");
      check_val("os_dec_count", 32'(count), 32'(3 - k));
    end
    idle(1, "os_exp");
    check_val("os_e4_irq", 32'(irq), 1);
    check_val("os_e4_status", 32'(status), 8'h02);
    idle(1, "os_wait");
    cycle(0, 0, 0, 1, "os_ack");
    check_val("os_ack_irq", 32'(irq), 0);

    // autoreload, PRESC 1, overflow on unserviced second expiry
    cycle(1, 0, 3, 0, "ar_cfg");
    cycle(1, 2, 1, 0, "ar_cfg");
    cycle(1, 1, 8'h07, 0, "ar_start");
    idle(7, "ar_run");
    check_val("ar_e7_irq", 32'(irq), 0);
    idle(1, "ar_exp1");
    check_val("ar_e8_irq", 32'(irq), 1);
    idle(8, "ar_run2");
    check_val("ar_e16_status", 32'(status), 8'h07);
    cycle(1, 3, 1, 0, "ar_clear");
    check_val("ar_clear_status", 32'(status), 8'h01);
    cycle(1, 3, 2, 0, "ar_stop");

    // ack landing on the expiry edge
    cycle(1, 1, 8'h07, 0, "ackexp_start");
    idle(7, "ackexp_run");
    cycle(0, 0, 0, 1, "ackexp_edge");
    check_val("ackexp_status", 32'(status), 8'h03);
    check_val("ackexp_irq", 32'(irq), 1);
    cycle(1, 3, 3, 0, "ackexp_stop");

    // stop freezes count, start reloads
    cycle(1, 0, 5, 0, "stop_cfg");
    cycle(1, 2, 0, 0, "stop_cfg");
    cycle(1, 1, 8'h01, 0, "stop_start");
    idle(3, "stop_run");
    check_val("stop_pre_count", 32'(count), 2);
    cycle(1, 3, 2, 0, "stop_cmd");
    idle(10, "stop_hold");
    check_val("stop_hold_count", 32'(count), 2);
    check_val("stop_hold_status", 32'(status), 0);
    cycle(1, 1, 8'h01, 0, "stop_restart");
    check_val("stop_restart_count", 32'(count), 5);

    // async reset mid-run
    cycle(1, 0, 7, 0, "rst_cfg");
    cycle(1, 1, 8'h05, 0, "rst_start");
    idle(2, "rst_run");
    check_val("rst_pre_count", 32'(count), 5);
    async_reset("midrun");
    idle(6, "rst_after");
    check_val("rst_after_count", 32'(count), 0);
    check_val("rst_after_status", 32'(status), 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int a, d;
      bit we, ack;
      we  = ($urandom_range(0, 99) < 15);
      ack = ($urandom_range(0, 99) < 5);
      a   = $urandom_range(0, 3);
      case (a)
        0: d = $urandom_range(0, 6);
        1: d = $urandom_range(0, 7);
        2: d = $urandom_range(0, 2);
        default: d = $urandom_range(0, 3);
      endcase
      cycle(we, a, d, ack, "rnd");
      if (n % 1000 == 999) async_reset("rnd");
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
